// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: display back-end for the alarm clock.
// Converts 24h BCD time to 12h with an AM/PM flag. Scans NUM_DIGITS
// seven-segment digits with per-digit blink, and drives a rotating alarm LED chase.
// LED0 is shared between the AM/PM indicator and the alarm chase.
// Optional build macro DISP_LZ_BLANK_EN: in 12h mode, blank a converted
// hours-tens digit of 0.
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_LEDS   = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int BLINK_DIV  = 25000000,
  parameter int ALARM_DIV  = 12500000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mod12_24,
  input  logic                    alarm,
  input  logic [4*NUM_DIGITS-1:0] disp_time,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [8+NUM_DIGITS-1:0] seg7s,
  output logic [NUM_LEDS-1:0]     leds
);
  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int AW = (ALARM_DIV > 1) ? $clog2(ALARM_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int HT = 4*NUM_DIGITS-4;  // hours tens nibble LSB
  localparam int HO = 4*NUM_DIGITS-8;  // hours ones nibble LSB

  logic [3:0]              h_tens, h_ones, h12;
  logic [7:0]              hours;
  logic                    hours_ok;
  logic [4*NUM_DIGITS-1:0] conv_time;
  logic                    conv_pm;
  logic [4*NUM_DIGITS-1:0] time_q;
  logic                    am_pm;
`ifdef DISP_LZ_BLANK_EN
  logic                    conv_lz;
  logic                    lz_q;
`endif

  // 24h -> 12h hours conversion; invalid hours pass through untouched
  always_comb begin
    h_tens    = disp_time[HT +: 4];
    h_ones    = disp_time[HO +: 4];
    hours     = {4'd0, h_tens} * 8'd10 + {4'd0, h_ones};
    hours_ok  = (h_tens <= 4'd2) && (h_ones <= 4'd9) && (hours <= 8'd23);
    h12       = hours[3:0];
    conv_time = disp_time;
    conv_pm   = 1'b0;
`ifdef DISP_LZ_BLANK_EN
    conv_lz   = 1'b0;
`endif
    if (mod12_24 && hours_ok) begin
      if (hours == 8'd0)
        h12 = 4'd12;
      else if (hours >= 8'd13)
        h12 = 4'(hours - 8'd12);
      conv_pm           = (hours >= 8'd12);
      conv_time[HT +: 4] = (h12 >= 4'd10) ? 4'd1 : 4'd0;
      conv_time[HO +: 4] = (h12 >= 4'd10) ? (h12 - 4'd10) : h12;
`ifdef DISP_LZ_BLANK_EN
      conv_lz = (h12 < 4'd10);
`endif
    end
  end

  // conversion result register (1-cycle latency)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q <= '0;
      am_pm  <= 1'b0;
`ifdef DISP_LZ_BLANK_EN
      lz_q   <= 1'b0;
`endif
    end else begin
      time_q <= conv_time;
      am_pm  <= conv_pm;
`ifdef DISP_LZ_BLANK_EN
      lz_q   <= conv_lz;
`endif
    end
  end

  logic [SW-1:0]         scan_cnt;
  logic [IW-1:0]         idx;
  logic [NUM_DIGITS-1:0] blink_q;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_phase;
  logic                  slot_end;

  assign slot_end = (scan_cnt == SW'(SCAN_DIV-1));

  // scan slot / digit index / blink timebase; blink_mask sampled per slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt    <= '0;
      idx         <= '0;
      blink_q     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (slot_end) begin
        scan_cnt <= '0;
        idx      <= (idx == IW'(NUM_DIGITS-1)) ? '0 : idx + 1'b1;
        blink_q  <= blink_mask;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blink_cnt == BW'(BLINK_DIV-1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  logic [3:0]            nib;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;

  // segment decode and anode select for the current slot
  always_comb begin
    nib = time_q[{idx, 2'b00} +: 4];
    case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
`ifdef DISP_LZ_BLANK_EN
    if (lz_q && (idx == IW'(NUM_DIGITS-1)))
      seg = 7'h7F;
`endif
    an = '1;
    if (!((scan_cnt == '0) || (blink_phase && blink_q[idx])))
      an[idx] = 1'b0;
  end

  // registered pin outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      seg7s <= '1;
    else
      seg7s <= {an, ~dp_mask[idx], seg};
  end

  logic [AW-1:0]       chase_cnt;
  logic [NUM_LEDS-1:0] pattern;

  // alarm chase: load bit 0 on first alarm cycle, rotate every ALARM_DIV cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern   <= '0;
      chase_cnt <= '0;
    end else if (!alarm) begin
      pattern   <= '0;
      chase_cnt <= '0;
    end else if (pattern == '0) begin
      pattern   <= {{(NUM_LEDS-1){1'b0}}, 1'b1};
      chase_cnt <= '0;
    end else if (chase_cnt == AW'(ALARM_DIV-1)) begin
      pattern   <= {pattern[NUM_LEDS-2:0], pattern[NUM_LEDS-1]};
      chase_cnt <= '0;
    end else begin
      chase_cnt <= chase_cnt + 1'b1;
    end
  end

  assign leds = {pattern[NUM_LEDS-1:1], alarm ? pattern[0] : (mod12_24 & am_pm)};

endmodule
